// File: rtl/temp_pwm_decoder.sv
// temp_pwm_decoder
// Measures the PTAT (pwm low) and CTAT (pwm high) phase lengths of the
// temperature-sensor sequencer's PWM output, in clk cycles. Each result sums
// 2^AVG_LOG2 PTAT/CTAT pairs and publishes both sums plus their signed
// difference as a raw temperature code. A phase that runs to TIMEOUT cycles
// raises a sticky error flag.

module temp_pwm_decoder #(
  parameter int W        = 16,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 60000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       pwm_in,
  output logic [W+AVG_LOG2-1:0]      ptat_sum,
  output logic [W+AVG_LOG2-1:0]      ctat_sum,
  output logic signed [W+AVG_LOG2:0] temp_diff,
  output logic                       valid,
  output logic                       busy,
  output logic                       err
);

  localparam int AW = W + AVG_LOG2;
  // The pair counter needs at least one bit, even when a single pair is averaged.
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PW-1:0] LAST_PAIR   = PW'((1 << AVG_LOG2) - 1);
  localparam logic [W-1:0]  CNT_MAX     = '1;
  localparam logic [W-1:0]  TIMEOUT_CNT = W'(TIMEOUT);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MEAS_PTAT = 3'd1;
  localparam logic [2:0] MEAS_CTAT = 3'd2;
  localparam logic [2:0] PUBLISH   = 3'd3;
  localparam logic [2:0] ERR       = 3'd4;

  logic [2:0]    state;
  logic          p_q;
  logic          p_qq;
  logic [W-1:0]  cnt;
  logic [PW-1:0] pairs;
  logic [AW-1:0] ptat_acc;
  logic [AW-1:0] ctat_acc;

  logic pwm_edge;
  logic pwm_fall;
  logic pwm_rise;

  assign pwm_edge = p_q != p_qq;
  assign pwm_fall = pwm_edge & ~p_q;
  assign pwm_rise = pwm_edge & p_q;
  assign busy     = state != IDLE;

  // Delay pwm_in for edge detection and count cycles since the last edge.
  // The counter restarts at 1 on an edge so that on the next edge it holds
  // exactly the number of cycles the previous level lasted.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      p_q  <= 1'b0;
      p_qq <= 1'b0;
      cnt  <= '0;
    end else begin
      p_q  <= pwm_in;
      p_qq <= p_q;
      if (pwm_edge) begin
        cnt <= W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Measurement FSM: accumulate phase lengths, publish a result every
  // 2^AVG_LOG2 pairs, and drop to IDLE on timeout or when disabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      pairs     <= '0;
      ptat_acc  <= '0;
      ctat_acc  <= '0;
      ptat_sum  <= '0;
      ctat_sum  <= '0;
      temp_diff <= '0;
      valid     <= 1'b0;
      err       <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        // Disabling discards any partial result; the error flag clears once
        // the block has settled in IDLE with enable still low.
        state    <= IDLE;
        pairs    <= '0;
        ptat_acc <= '0;
        ctat_acc <= '0;
        if (state == IDLE) begin
          err <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: begin
            // Only a falling edge starts a measurement, so any partial phase
            // in progress when enable rose is ignored.
            if (pwm_fall) begin
              state <= MEAS_PTAT;
            end
          end

          MEAS_PTAT: begin
            // An edge wins over a timeout in the same cycle.
            if (pwm_rise) begin
              ptat_acc <= ptat_acc + AW'(cnt);
              state    <= MEAS_CTAT;
            end else if (cnt >= TIMEOUT_CNT) begin
              state <= ERR;
            end
          end

          MEAS_CTAT: begin
            // The fall that closes a CTAT phase also opens the next PTAT
            // phase, so no cycles are lost between pairs.
            if (pwm_fall) begin
              ctat_acc <= ctat_acc + AW'(cnt);
              pairs    <= pairs + 1'b1;
              state    <= (pairs == LAST_PAIR) ? PUBLISH : MEAS_PTAT;
            end else if (cnt >= TIMEOUT_CNT) begin
              state <= ERR;
            end
          end

          PUBLISH: begin
            ptat_sum  <= ptat_acc;
            ctat_sum  <= ctat_acc;
            temp_diff <= $signed({1'b0, ptat_acc}) - $signed({1'b0, ctat_acc});
            valid     <= 1'b1;
            ctat_acc  <= '0;
            pairs     <= '0;
            // The counter keeps running here; a rise that lands in this
            // cycle closes the new PTAT phase immediately.
            if (pwm_rise) begin
              ptat_acc <= AW'(cnt);
              state    <= MEAS_CTAT;
            end else begin
              ptat_acc <= '0;
              state    <= MEAS_PTAT;
            end
          end

          ERR: begin
            // Published results are left untouched; only the partial
            // accumulation is dropped.
            err      <= 1'b1;
            pairs    <= '0;
            ptat_acc <= '0;
            ctat_acc <= '0;
            state    <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_temp_pwm_decoder.sv
// tb_temp_pwm_decoder
// Directed bench for temp_pwm_decoder. Two instances share the stimulus:
// dut_a averages 4 pairs, dut_b reports every single pair. Both use a short
// timeout so stalls can be exercised quickly.

module tb_temp_pwm_decoder;

  localparam int W    = 16;
  localparam int TO   = 500;
  localparam int AW_A = W + 2;
  localparam int AW_B = W;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic pwm_in;

  logic [AW_A-1:0]      ptat_a, ctat_a;
  logic signed [AW_A:0] diff_a;
  logic                 valid_a, busy_a, err_a;

  logic [AW_B-1:0]      ptat_b, ctat_b;
  logic signed [AW_B:0] diff_b;
  logic                 valid_b, busy_b, err_b;

  temp_pwm_decoder #(.W(W), .AVG_LOG2(2), .TIMEOUT(TO)) dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .ptat_sum  (ptat_a),
    .ctat_sum  (ctat_a),
    .temp_diff (diff_a),
    .valid     (valid_a),
    .busy      (busy_a),
    .err       (err_a)
  );

  temp_pwm_decoder #(.W(W), .AVG_LOG2(0), .TIMEOUT(TO)) dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .pwm_in    (pwm_in),
    .ptat_sum  (ptat_b),
    .ctat_sum  (ctat_b),
    .temp_diff (diff_b),
    .valid     (valid_b),
    .busy      (busy_b),
    .err       (err_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Result capture on every valid pulse, sampled on the falling edge.
  longint a_ptat[32], a_ctat[32], a_diff[32];
  longint b_ptat[32], b_ctat[32], b_diff[32];
  int     a_cyc[32], b_cyc[32];
  int     a_n = 0, b_n = 0;
  int     busy_n = 0;
  int     err_a_cyc = -1;
  logic   err_a_prev = 1'b0;

  always @(negedge clk) begin
    if (valid_a === 1'b1) begin
      if (a_n < 32) begin
        a_ptat[a_n] = ptat_a; a_ctat[a_n] = ctat_a; a_diff[a_n] = diff_a; a_cyc[a_n] = cyc;
      end
      a_n++;
    end
    if (valid_b === 1'b1) begin
      if (b_n < 32) begin
        b_ptat[b_n] = ptat_b; b_ctat[b_n] = ctat_b; b_diff[b_n] = diff_b; b_cyc[b_n] = cyc;
      end
      b_n++;
    end
    if (busy_a === 1'b1 || busy_b === 1'b1) busy_n++;
    if (err_a === 1'b1 && err_a_prev !== 1'b1) err_a_cyc = cyc;
    err_a_prev = err_a;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Hold pwm_in at lvl for n sampling edges; returns #1 after the last edge.
  task automatic hold(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int lows1[4] = '{50, 52, 48, 50};
  int base_a, base_b, base_busy, t0, t1;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    pwm_in  = 1'b0;
    @(posedge clk);
    #1;

    // Reset with pwm toggling.
    hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1);
    check("rst_ptat",  ptat_a, 0);
    check("rst_ctat",  ctat_a, 0);
    check("rst_diff",  diff_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_err",   err_a, 0);
    check("rst_busy_b", busy_b, 0);

    // Disabled with pwm toggling: never busy, never valid.
    reset_n   = 1'b1;
    base_busy = busy_n;
    base_a    = a_n;
    base_b    = b_n;
    for (int i = 0; i < 10; i++) begin
      hold(1'b0, 3);
      hold(1'b1, 4);
    end
    check("idle_busy_cycles", busy_n - base_busy, 0);
    check("idle_valid_count", (a_n - base_a) + (b_n - base_b), 0);

    // Single pair, enable raised mid-way through a high phase.
    hold(1'b1, 5);
    enable = 1'b1;
    hold(1'b1, 12);
    base_b = b_n;
    hold(1'b0, 100);
    hold(1'b1, 60);
    t0 = cyc;
    hold(1'b0, 100);
    check("single_count",   b_n - base_b, 1);
    check("single_latency", b_cyc[base_b] - t0, 3);
    check("single_ptat",    b_ptat[base_b], 100);
    check("single_ctat",    b_ctat[base_b], 60);
    check("single_diff",    b_diff[base_b], 40);

    // Startup alignment: enable raised mid-way through a low phase.
    reset_n = 1'b0;
    enable  = 1'b0;
    hold(1'b0, 3);
    reset_n = 1'b1;
    hold(1'b0, 10);
    enable = 1'b1;
    hold(1'b0, 20);
    hold(1'b1, 45);
    base_b = b_n;
    hold(1'b0, 100);
    hold(1'b1, 60);
    hold(1'b0, 100);
    check("align_count", b_n - base_b, 1);
    check("align_ptat",  b_ptat[base_b], 100);
    check("align_ctat",  b_ctat[base_b], 60);
    check("align_diff",  b_diff[base_b], 40);

    // Averaging over 4 pairs, back-to-back results, then a stall.
    reset_n = 1'b0;
    enable  = 1'b0;
    hold(1'b1, 3);
    reset_n = 1'b1;
    enable  = 1'b1;
    hold(1'b1, 20);
    base_a = a_n;
    for (int i = 0; i < 4; i++) begin
      hold(1'b0, lows1[i]);
      hold(1'b1, 70);
    end
    check("avg_busy", busy_a, 1);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      hold(1'b0, 40);
      hold(1'b1, 30);
    end
    t1 = cyc;
    hold(1'b0, 600);
    check("avg_count",    a_n - base_a, 2);
    check("avg1_latency", a_cyc[base_a] - t0, 3);
    check("avg1_ptat",    a_ptat[base_a], 200);
    check("avg1_ctat",    a_ctat[base_a], 280);
    check("avg1_diff",    a_diff[base_a], -80);
    check("avg2_latency", a_cyc[base_a+1] - t1, 3);
    check("avg2_ptat",    a_ptat[base_a+1], 160);
    check("avg2_ctat",    a_ctat[base_a+1], 120);
    check("avg2_diff",    a_diff[base_a+1], 40);

    check("to_err",      err_a, 1);
    check("to_busy",     busy_a, 0);
    check("to_hold_ptat", ptat_a, 160);
    check("to_hold_ctat", ctat_a, 120);
    check("to_hold_diff", diff_a, 40);
    check("to_err_time_window",
          ((err_a_cyc - t1) >= TO - 2 && (err_a_cyc - t1) <= TO + 6) ? 1 : 0, 1);
    check("to_err_b",    err_b, 1);

    // Recovery: enable 0 -> 1 clears err, measurement resumes.
    hold(1'b1, 10);
    enable = 1'b0;
    hold(1'b1, 4);
    check("clr_err_a", err_a, 0);
    check("clr_err_b", err_b, 0);
    enable = 1'b1;
    hold(1'b1, 10);
    base_a = a_n;
    base_b = b_n;
    for (int i = 0; i < 4; i++) begin
      hold(1'b0, 80);
      hold(1'b1, 40);
    end
    hold(1'b0, 10);
    check("rec_count_a", a_n - base_a, 1);
    check("rec_ptat_a",  a_ptat[base_a], 320);
    check("rec_ctat_a",  a_ctat[base_a], 160);
    check("rec_diff_a",  a_diff[base_a], 160);
    check("rec_count_b", b_n - base_b, 4);
    check("rec_ptat_b",  b_ptat[b_n-1], 80);
    check("rec_ctat_b",  b_ctat[b_n-1], 40);
    check("rec_diff_b",  b_diff[b_n-1], 40);

    // Abort in the third of 4 pairs, then fresh pairs only.
    base_a = a_n;
    hold(1'b0, 20);
    hold(1'b1, 20);
    hold(1'b0, 30);
    hold(1'b1, 20);
    hold(1'b0, 30);
    hold(1'b1, 10);
    check("abort_busy_before", busy_a, 1);
    enable = 1'b0;
    hold(1'b1, 1);
    check("abort_busy_after", busy_a, 0);
    hold(1'b1, 10);
    check("abort_no_valid", a_n - base_a, 0);
    enable = 1'b1;
    hold(1'b1, 5);
    for (int i = 0; i < 4; i++) begin
      hold(1'b0, 25);
      hold(1'b1, 35);
    end
    hold(1'b0, 10);
    check("abort_count", a_n - base_a, 1);
    check("abort_ptat",  a_ptat[base_a], 100);
    check("abort_ctat",  a_ctat[base_a], 140);
    check("abort_diff",  a_diff[base_a], -40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/temp_pwm_decoder.md
Name: temp_pwm_decoder

Overview:
- Downstream consumer of the temperature-sensor sequencer's PWM output.
- The sequencer toggles PWM at the end of every PTAT and CTAT phase. PWM low = PTAT phase, PWM high = CTAT phase.
- This block measures both phase lengths in clk cycles and averages them over 2^AVG_LOG2 PTAT/CTAT pairs.
- It publishes PTAT sum, CTAT sum and their signed difference as a raw temperature code, and flags a stalled sensor.

Parameters:
- W, 16, width of the per-phase cycle counter; saturates at 2^W-1.
- AVG_LOG2, 2, log2 of the number of PTAT/CTAT pairs accumulated per result.
- TIMEOUT, 60000, max cycles in one phase before the error flag is set; must be < 2^W-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active low.
- enable  in  1  measurement enable; low forces IDLE.
- pwm_in  in  1  PWM from the sequencer, same clock domain.
- ptat_sum  out  W+AVG_LOG2  accumulated PTAT (pwm low) cycles.
- ctat_sum  out  W+AVG_LOG2  accumulated CTAT (pwm high) cycles.
- temp_diff  out  W+AVG_LOG2+1  signed two's complement ptat_sum - ctat_sum.
- valid  out  1  one-cycle pulse; result outputs are updated in the same cycle.
- busy  out  1  high whenever state is not IDLE.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-low. While reset_n=0 at a clk rising edge:
  - state=IDLE; all counters and accumulators 0.
  - ptat_sum=0, ctat_sum=0, temp_diff=0, valid=0, busy=0, err=0.
  - p_q and p_qq (the pwm_in delay registers) = 0.
- Edge detect:
  - p_q <= pwm_in; p_qq <= p_q.
  - edge = p_q != p_qq; fall = edge & ~p_q; rise = edge & p_q.
- Phase counter cnt (W bits):
  - edge -> cnt <= 1.
  - otherwise cnt <= cnt+1, saturating at 2^W-1.
  - When pwm_in holds a level for N cycles, cnt on the edge cycle equals N.
- States:
  - IDLE:
    - enable=0 -> stay; clear pair count and accumulators; err cleared.
    - enable=1 and fall -> MEAS_PTAT. The first measurement always starts on a falling edge; partial phases are discarded.
  - MEAS_PTAT:
    - rise -> ptat_acc += cnt; go MEAS_CTAT.
    - cnt reaches TIMEOUT -> ERR.
  - MEAS_CTAT:
    - fall -> ctat_acc += cnt; pairs += 1.
    - If pairs was 2^AVG_LOG2-1, go to PUBLISH.
    - Otherwise go to MEAS_PTAT. The same falling edge starts the next PTAT phase, so no cycles are lost.
    - cnt reaches TIMEOUT -> ERR.
  - PUBLISH (1 cycle):
    - Load ptat_sum, ctat_sum, temp_diff from the accumulators; pulse valid.
    - Clear accumulators and pairs; go MEAS_PTAT.
    - Requirement: cnt keeps running through PUBLISH, and an edge arriving in PUBLISH is honoured (a rise goes to MEAS_CTAT with the PTAT capture).
    - Latency: valid is asserted 1 cycle after the fall-detect cycle, i.e. 3 clk after the pwm_in transition.
  - ERR:
    - err <= 1 (sticky); clear accumulators and pairs; go IDLE.
    - Result outputs keep their last published values.
- Widths: accumulators W+AVG_LOG2 bits and cannot overflow. temp_diff is sign-extended subtraction.
- Simultaneous events:
  - A valid edge in the same cycle that cnt hits TIMEOUT: the edge wins.
  - enable dropping mid-measurement: next cycle goes IDLE, accumulators are discarded, and valid is not pulsed.
  - reset_n low overrides everything, including PUBLISH.
- Outputs hold between valid pulses. busy=0 only in IDLE.

Test Plan:
- Reset and idle: reset_n=0 for 3 clk with pwm_in toggling -> all outputs 0. enable=0 with pwm toggling -> busy=0, valid never pulses.
- Single pair (AVG_LOG2=0): enable=1; pwm_in low 100, high 60, low 100 cycles -> one valid pulse 3 clk after the second falling transition. ptat_sum=100, ctat_sum=60, temp_diff=+40.
- Averaging (default AVG_LOG2=2): 4 pairs with low/high = 50/70, 52/70, 48/70, 50/70 -> single valid pulse; ptat_sum=200, ctat_sum=280, temp_diff=-80. The next 4 pairs produce the next pulse with no dropped cycles.
- Startup alignment: enable asserted while pwm_in is high mid-phase -> that partial phase is ignored; measurement starts at the first fall. Results match the single-pair case.
- Timeout: TIMEOUT=500; pwm_in held low for 600 cycles after a fall -> err=1 at cycle ~500, state IDLE, outputs unchanged. enable toggled 0->1 clears err; normal pairs then resume producing valid.
- Abort: enable deasserted midway through the third of 4 pairs -> no valid, busy=0 next cycle. Re-enable gives results counted only from new pairs.
